// File: rtl/memory_arbiter_n.sv
// memory_arbiter_n: N-requester fixed-priority / round-robin arbiter onto a single generic memory bus
module memory_arbiter_n #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_REQ-1:0]            req_ren,
  input  logic [NUM_REQ-1:0]            req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_byte_en,
  output logic [NUM_REQ-1:0]            req_busy,
  output logic [NUM_REQ*DATA_W-1:0]     req_rdata,
  output logic                          mem_ren,
  output logic                          mem_wen,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_byte_en,
  input  logic                          mem_busy,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state, w_nstate;
  logic [IW-1:0] r_owner, w_nowner, r_rr_ptr, w_win, w_sel, r_grant_id;
  logic [IW:0] w_j;
  logic [NUM_REQ-1:0] w_req;
  logic w_found, w_act, r_grant_valid;
  assign w_req = req_ren | req_wen;
  // Scan upward from rr_ptr with explicit wrap; rr_ptr is held at 0 in fixed mode.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = {1'b0, r_rr_ptr} + (IW+1)'(k);
      w_j = (w_j >= (IW+1)'(NUM_REQ)) ? w_j - (IW+1)'(NUM_REQ) : w_j;
      if (!w_found && w_req[w_j[IW-1:0]]) begin
        w_found = 1'b1;
        w_win = w_j[IW-1:0];
      end
    end
  end
  assign w_act = nRST & ((r_state == LOCKED) | w_found);
  assign w_sel = (r_state == LOCKED) ? r_owner : w_win;
  always_comb begin
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_byte_en = '0;
    req_busy = '1;
    req_rdata = '0;
    if (w_act) begin
      mem_ren = req_ren[w_sel];
      mem_wen = req_wen[w_sel];
      mem_addr = req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[int'(w_sel)*DATA_W +: DATA_W];
      mem_byte_en = req_byte_en[int'(w_sel)*(DATA_W/8) +: DATA_W/8];
      req_busy[w_sel] = mem_busy;
      req_rdata[int'(w_sel)*DATA_W +: DATA_W] = mem_rdata;
    end
  end
  always_comb begin
    w_nstate = r_state;
    w_nowner = r_owner;
    if (r_state == IDLE) begin
      if (w_found && mem_busy) begin
        w_nstate = LOCKED;
        w_nowner = w_win;
      end
    end else if (!mem_busy) begin
      w_nstate = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else r_state <= w_nstate;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_owner <= '0;
      r_rr_ptr <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id <= '0;
    end else begin
      r_owner <= w_nowner;
      r_grant_valid <= (w_nstate == LOCKED);
      r_grant_id <= (w_nstate == LOCKED) ? w_nowner : '0;
      if (ARB_MODE != 0 && w_act && !mem_busy)
        r_rr_ptr <= (w_sel == IW'(NUM_REQ-1)) ? '0 : w_sel + 1'b1;
    end
  end
  assign grant_valid = r_grant_valid;
  assign grant_id = r_grant_id;
endmodule

// File: tb/tb_memory_arbiter_n.sv
// tb_memory_arbiter_n: directed bench for a fixed-priority and a round-robin instance sharing one stimulus
module tb_memory_arbiter_n;
  logic CLK = 1'b0;
  logic nRST;
  logic [2:0] req_ren, req_wen;
  logic [95:0] req_addr, req_wdata;
  logic [11:0] req_byte_en;
  logic mem_busy;
  logic [31:0] mem_rdata;
  logic [2:0] f_req_busy, r_req_busy;
  logic [95:0] f_req_rdata, r_req_rdata;
  logic f_mem_ren, f_mem_wen, r_mem_ren, r_mem_wen;
  logic [31:0] f_mem_addr, f_mem_wdata, r_mem_addr, r_mem_wdata;
  logic [3:0] f_mem_byte_en, r_mem_byte_en;
  logic f_grant_valid, r_grant_valid;
  logic [1:0] f_grant_id, r_grant_id;
  int errs = 0;
  int checks = 0;
  logic [31:0] addr_of [3];

  memory_arbiter_n #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_f (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_busy(f_req_busy), .req_rdata(f_req_rdata),
    .mem_ren(f_mem_ren), .mem_wen(f_mem_wen), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_byte_en(f_mem_byte_en), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
    .grant_valid(f_grant_valid), .grant_id(f_grant_id));

  memory_arbiter_n #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_r (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_busy(r_req_busy), .req_rdata(r_req_rdata),
    .mem_ren(r_mem_ren), .mem_wen(r_mem_wen), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_byte_en(r_mem_byte_en), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
    .grant_valid(r_grant_valid), .grant_id(r_grant_id));

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    req_ren = '0;
    req_wen = '0;
    mem_busy = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    req_ren = 3'b111;
    mem_busy = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (f_mem_ren !== 1'b0 || f_mem_wen !== 1'b0 || f_mem_addr !== 32'h0) begin
        errs++;
        $display("FAIL reset_mem got ren=%b wen=%b addr=%h exp 0 0 0", f_mem_ren, f_mem_wen, f_mem_addr);
      end
      checks++;
      if (f_req_busy !== 3'b111 || f_req_rdata !== 96'h0) begin
        errs++;
        $display("FAIL reset_req got busy=%b rdata=%h exp 111 0", f_req_busy, f_req_rdata);
      end
      checks++;
      if (f_grant_valid !== 1'b0 || f_grant_id !== 2'd0 || r_grant_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset_grant got gv=%b gid=%0d rgv=%b exp 0 0 0", f_grant_valid, f_grant_id, r_grant_valid);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    req_ren = 3'b010;
    mem_busy = 1'b1;
    mem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (f_mem_addr !== 32'h100 || f_mem_ren !== 1'b1 || f_req_busy !== 3'b111) begin
        errs++;
        $display("FAIL single_busy c=%0d got addr=%h ren=%b busy=%b exp 100 1 111", c, f_mem_addr, f_mem_ren, f_req_busy);
      end
      checks++;
      if (f_grant_valid !== (c != 0) || f_grant_id !== ((c != 0) ? 2'd1 : 2'd0)) begin
        errs++;
        $display("FAIL single_grant c=%0d got gv=%b gid=%0d exp %b %0d", c, f_grant_valid, f_grant_id, c != 0, (c != 0) ? 1 : 0);
      end
      tick();
    end
    mem_busy = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (f_req_busy !== 3'b101 || f_req_rdata !== {32'h0, 32'hDEADBEEF, 32'h0}) begin
      errs++;
      $display("FAIL single_done got busy=%b rdata=%h exp 101 slice1=deadbeef", f_req_busy, f_req_rdata);
    end
    tick();
    req_ren = '0;
    checks++;
    if (f_grant_valid !== 1'b0 || f_grant_id !== 2'd0) begin
      errs++;
      $display("FAIL single_release got gv=%b gid=%0d exp 0 0", f_grant_valid, f_grant_id);
    end
  endtask

  task automatic test_fixed;
    int ord [4];
    logic [95:0] er;
    logic [2:0] eb;
    ord = '{0, 0, 1, 2};
    do_reset();
    req_ren = 3'b111;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = 32'hC0DE0000 + 32'(k);
      er = '0;
      er[ord[k]*32 +: 32] = mem_rdata;
      for (int c = 0; c < 3; c++) begin
        mem_busy = (c < 2);
        eb = (c < 2) ? 3'b111 : ~(3'b001 << ord[k]);
        #1;
        checks++;
        if (f_mem_addr !== addr_of[ord[k]] || f_req_busy !== eb || f_req_rdata !== er) begin
          errs++;
          $display("FAIL fixed_order k=%0d c=%0d got addr=%h busy=%b rdata=%h exp %h %b %h", k, c, f_mem_addr, f_req_busy, f_req_rdata, addr_of[ord[k]], eb, er);
        end
        if (c == 1) begin
          checks++;
          if (f_grant_valid !== 1'b1 || f_grant_id !== 2'(ord[k])) begin
            errs++;
            $display("FAIL fixed_grant k=%0d got gv=%b gid=%0d exp 1 %0d", k, f_grant_valid, f_grant_id, ord[k]);
          end
        end
        tick();
      end
      if (k >= 1) req_ren[ord[k]] = 1'b0;
    end
  endtask

  task automatic test_rr;
    int ord [5];
    logic [95:0] er;
    logic [2:0] eb;
    ord = '{0, 1, 2, 0, 1};
    do_reset();
    req_ren = 3'b111;
    for (int k = 0; k < 5; k++) begin
      mem_rdata = 32'h5A000000 + 32'(k);
      er = '0;
      er[ord[k]*32 +: 32] = mem_rdata;
      for (int c = 0; c < 3; c++) begin
        mem_busy = (c < 2);
        eb = (c < 2) ? 3'b111 : ~(3'b001 << ord[k]);
        #1;
        checks++;
        if (r_mem_addr !== addr_of[ord[k]] || r_req_busy !== eb || r_req_rdata !== er) begin
          errs++;
          $display("FAIL rr_order k=%0d c=%0d got addr=%h busy=%b rdata=%h exp %h %b %h", k, c, r_mem_addr, r_req_busy, r_req_rdata, addr_of[ord[k]], eb, er);
        end
        if (c == 1) begin
          checks++;
          if (r_grant_valid !== 1'b1 || r_grant_id !== 2'(ord[k])) begin
            errs++;
            $display("FAIL rr_grant k=%0d got gv=%b gid=%0d exp 1 %0d", k, r_grant_valid, r_grant_id, ord[k]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_lock;
    do_reset();
    req_ren = 3'b100;
    mem_busy = 1'b1;
    #1;
    checks++;
    if (f_mem_addr !== 32'h200) begin
      errs++;
      $display("FAIL lock_start got addr=%h exp 200", f_mem_addr);
    end
    tick();
    req_ren = 3'b101;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (f_mem_addr !== 32'h200 || f_req_busy !== 3'b111 || f_grant_id !== 2'd2) begin
        errs++;
        $display("FAIL lock_hold c=%0d got addr=%h busy=%b gid=%0d exp 200 111 2", c, f_mem_addr, f_req_busy, f_grant_id);
      end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (f_mem_addr !== 32'h200 || f_req_busy !== 3'b011) begin
      errs++;
      $display("FAIL lock_done got addr=%h busy=%b exp 200 011", f_mem_addr, f_req_busy);
    end
    tick();
    mem_busy = 1'b1;
    #1;
    checks++;
    if (f_mem_addr !== 32'h080 || f_req_busy !== 3'b111) begin
      errs++;
      $display("FAIL lock_next got addr=%h busy=%b exp 80 111", f_mem_addr, f_req_busy);
    end
    tick();
    checks++;
    if (f_grant_valid !== 1'b1 || f_grant_id !== 2'd0) begin
      errs++;
      $display("FAIL lock_next_grant got gv=%b gid=%0d exp 1 0", f_grant_valid, f_grant_id);
    end
    mem_busy = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait;
    do_reset();
    req_wdata[63:32] = 32'hA5A5A5A5;
    req_byte_en[7:4] = 4'hF;
    req_wen = 3'b010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (f_mem_wen !== 1'b1 || f_mem_ren !== 1'b0 || f_mem_wdata !== 32'hA5A5A5A5 || f_mem_byte_en !== 4'hF || f_mem_addr !== 32'h100) begin
        errs++;
        $display("FAIL zw_bus c=%0d got wen=%b ren=%b wdata=%h be=%h addr=%h exp 1 0 a5a5a5a5 f 100", c, f_mem_wen, f_mem_ren, f_mem_wdata, f_mem_byte_en, f_mem_addr);
      end
      checks++;
      if (f_req_busy !== 3'b101 || f_grant_valid !== 1'b0 || f_grant_id !== 2'd0) begin
        errs++;
        $display("FAIL zw_state c=%0d got busy=%b gv=%b gid=%0d exp 101 0 0", c, f_req_busy, f_grant_valid, f_grant_id);
      end
      tick();
    end
    req_wen = '0;
    req_ren = 3'b111;
    mem_busy = 1'b1;
    #1;
    checks++;
    if (r_mem_addr !== 32'h200 || f_mem_addr !== 32'h080) begin
      errs++;
      $display("FAIL zw_rr_ptr got rr_addr=%h fixed_addr=%h exp 200 80", r_mem_addr, f_mem_addr);
    end
    tick();
  endtask

  task automatic test_reset_locked;
    do_reset();
    req_ren = 3'b010;
    mem_busy = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    tick();
    checks++;
    if (f_grant_valid !== 1'b1 || f_grant_id !== 2'd1) begin
      errs++;
      $display("FAIL rstlk_pre got gv=%b gid=%0d exp 1 1", f_grant_valid, f_grant_id);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (f_grant_valid !== 1'b0 || f_grant_id !== 2'd0 || f_req_busy !== 3'b111 || f_mem_ren !== 1'b0 || f_req_rdata !== 96'h0) begin
      errs++;
      $display("FAIL rstlk_async got gv=%b gid=%0d busy=%b ren=%b rdata=%h exp 0 0 111 0 0", f_grant_valid, f_grant_id, f_req_busy, f_mem_ren, f_req_rdata);
    end
    tick();
    nRST = 1'b1;
    mem_rdata = '0;
    #1;
    checks++;
    if (f_mem_addr !== 32'h100 || f_mem_ren !== 1'b1 || f_grant_valid !== 1'b0) begin
      errs++;
      $display("FAIL rstlk_reissue got addr=%h ren=%b gv=%b exp 100 1 0", f_mem_addr, f_mem_ren, f_grant_valid);
    end
    tick();
    checks++;
    if (f_grant_valid !== 1'b1 || f_grant_id !== 2'd1) begin
      errs++;
      $display("FAIL rstlk_relock got gv=%b gid=%0d exp 1 1", f_grant_valid, f_grant_id);
    end
    mem_busy = 1'b0;
    mem_rdata = 32'hFEEDFACE;
    #1;
    checks++;
    if (f_req_busy !== 3'b101 || f_req_rdata !== {32'h0, 32'hFEEDFACE, 32'h0}) begin
      errs++;
      $display("FAIL rstlk_done got busy=%b rdata=%h exp 101 slice1=feedface", f_req_busy, f_req_rdata);
    end
    tick();
    req_ren = '0;
    checks++;
    if (f_grant_valid !== 1'b0) begin
      errs++;
      $display("FAIL rstlk_idle got gv=%b exp 0", f_grant_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    req_ren = '0;
    req_wen = '0;
    mem_busy = 1'b0;
    mem_rdata = '0;
    addr_of[0] = 32'h080;
    addr_of[1] = 32'h100;
    addr_of[2] = 32'h200;
    req_addr = {addr_of[2], addr_of[1], addr_of[0]};
    req_wdata = {32'h33333333, 32'h22222222, 32'h11111111};
    req_byte_en = 12'h731;
    tick();
    test_reset();
    test_single();
    test_fixed();
    test_rr();
    test_lock();
    test_zero_wait();
    test_reset_locked();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
